painterengine_gpu_pixel_packer: RTL and testbench

Parametrised pixel-stream packer for the GPU display path. Accepts one 32-bit pixel per beat in any of four ARGB byte orders, strips alpha, converts to RGB888/BGR888/RGB565/BGR565, and packs the resulting byte stream densely into OUT_BYTES-wide output words. Both sides use valid/ready backpressure, and an optional flush pads and drains a partial word at end of line or frame. It sits between the GPU render/blit engine and the framebuffer write DMA.

---
 rtl/painterengine_gpu_pixel_packer.sv | 184 ++++++++++++++++++
 tb/tb_painterengine_gpu_pixel_packer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_pixel_packer.sv
// Pixel packer: ARGB beats -> RGB888/BGR888/RGB565/BGR565 bytes, densely packed.
// Optional flush/pad/drain built when PAINTERENGINE_GPU_PACKER_FLUSH_EN is defined.
module painterengine_gpu_pixel_packer #(
  parameter int OUT_BYTES       = 4,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                   i_wire_clock,
  input  logic                   i_wire_reset,
  input  logic [31:0]            i_wire_color,
  input  logic                   i_wire_valid,
  output logic                   o_wire_ready,
  input  logic [1:0]             i_wire_iargb_mode,
  input  logic [1:0]             i_wire_ofmt,
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
  input  logic                   i_wire_flush,
  output logic                   o_wire_flush_done,
`endif
  output logic [OUT_BYTES*8-1:0] o_wire_data,
  output logic                   o_wire_valid,
  input  logic                   i_wire_ready
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] OB_C    = CW'(OUT_BYTES);

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUT_BYTES*8-1:0] data_q, data_d;
  logic [OUT_BYTES*8-1:0] head;
  logic                   vld_q, vld_d;
  logic [7:0]             r, g, b;
  logic [7:0]             pb [3];
  logic [1:0]             pn;
  logic                   run, pad, accept, pop;

`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
  localparam int LW = $clog2(OUT_BYTES);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_PAD   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0] st_q, st_d;
  logic       done_q, done_d;
  logic       aligned;

  assign aligned = (cnt_q[LW-1:0] == '0);
  assign run     = (st_q == S_RUN);
  assign pad     = (st_q == S_PAD) && !aligned;

  always_comb begin
    st_d   = st_q;
    done_d = 1'b0;
    unique case (st_q)
      S_RUN:   if (i_wire_flush) st_d = S_PAD;
      S_PAD:   if (aligned) st_d = S_DRAIN;
      S_DRAIN: begin
        if (cnt_q == '0 && (!vld_q || i_wire_ready)) begin
          st_d   = S_RUN;
          done_d = 1'b1;
        end
      end
      default: st_d = S_RUN;
    endcase
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      st_q   <= S_RUN;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= done_d;
    end
  end

  assign o_wire_flush_done = done_q;
`else
  assign run = 1'b1;
  assign pad = 1'b0;
`endif

  // Ready reserves a full 3-byte slot regardless of format.
  assign o_wire_ready = !i_wire_reset && run &&
                        ((DEPTH_C - cnt_q) >= CW'(3));
  assign accept = i_wire_valid && o_wire_ready;
  assign pop    = (cnt_q >= OB_C) && (!vld_q || i_wire_ready);

  always_comb begin
    r = i_wire_color[23:16];
    g = i_wire_color[15:8];
    b = i_wire_color[7:0];
    unique case (i_wire_iargb_mode)
      2'd1: begin
        r = i_wire_color[7:0];
        b = i_wire_color[23:16];
      end
      2'd2: begin
        r = i_wire_color[31:24];
        g = i_wire_color[23:16];
        b = i_wire_color[15:8];
      end
      2'd3: begin
        r = i_wire_color[15:8];
        g = i_wire_color[23:16];
        b = i_wire_color[31:24];
      end
      default: ;
    endcase
  end

  always_comb begin
    pb[0] = r;
    pb[1] = g;
    pb[2] = b;
    pn    = 2'd0;
    unique case (i_wire_ofmt)
      2'd1: begin
        pb[0] = b;
        pb[2] = r;
      end
      2'd2: begin
        pb[0] = {g[4:2], b[7:3]};
        pb[1] = {r[7:3], g[7:5]};
      end
      2'd3: begin
        pb[0] = {g[4:2], r[7:3]};
        pb[1] = {b[7:3], g[7:5]};
      end
      default: ;
    endcase
    if (accept) begin
      pn = i_wire_ofmt[1] ? 2'd2 : 2'd3;
    end else if (pad) begin
      pn    = 2'd1;
      pb[0] = 8'h00;
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < OUT_BYTES; i++)
      head[i*8 +: 8] = mem_q[rd_q + AW'(i)];
  end

  always_comb begin
    wr_d   = wr_q + AW'(pn);
    rd_d   = pop ? rd_q + AW'(OUT_BYTES) : rd_q;
    cnt_d  = cnt_q + CW'(pn) - (pop ? OB_C : '0);
    data_d = pop ? head : data_q;
    vld_d  = vld_q;
    if (pop)               vld_d = 1'b1;
    else if (i_wire_ready) vld_d = 1'b0;
  end

  always_ff @(posedge i_wire_clock) begin
    for (int k = 0; k < 3; k++)
      if (k < int'(pn)) mem_q[wr_q + AW'(k)] <= pb[k];
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign o_wire_data  = data_q;
  assign o_wire_valid = vld_q;

endmodule

// File: tb/tb_painterengine_gpu_pixel_packer.sv
// Bench for painterengine_gpu_pixel_packer: byte-queue scoreboard, random traffic.
// Flush scenarios are built when PAINTERENGINE_GPU_PACKER_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_painterengine_gpu_pixel_packer;
  localparam int OB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   col = '0;
  logic          vin = 1'b0;
  logic          o_rdy;
  logic [1:0]    mode = '0;
  logic [1:0]    fmt = '0;
  logic [OB*8-1:0] o_data;
  logic          o_valid;
  logic          oready = 1'b0;
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
  logic          flush = 1'b0;
  logic          done;
  bit            flushing = 1'b0;
  bit            prev_done = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int rmode = 1;
  int done_cnt = 0;
  logic [7:0]      q[$];
  logic [OB*8-1:0] got[$];
  logic [OB*8-1:0] ew;
  logic [OB*8-1:0] held;
  bit              hold_pend = 1'b0;

  always #5 clk = ~clk;

  painterengine_gpu_pixel_packer #(
    .OUT_BYTES(OB),
    .FIFO_DEPTH_LOG2(5)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_reset(rst),
    .i_wire_color(col),
    .i_wire_valid(vin),
    .o_wire_ready(o_rdy),
    .i_wire_iargb_mode(mode),
    .i_wire_ofmt(fmt),
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    .i_wire_flush(flush),
    .o_wire_flush_done(done),
`endif
    .o_wire_data(o_data),
    .o_wire_valid(o_valid),
    .i_wire_ready(oready)
  );

  task automatic chk(input string tag, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Reference: pick channels by shifting, 565 built as a 16-bit value.
  function automatic void expand(input logic [31:0] c,
                                 input logic [1:0] m,
                                 input logic [1:0] f);
    int R, G, B, t, v;
    R = 0; G = 0; B = 0;
    case (m)
      2'd0: begin R = int'((c >> 16) & 32'hFF); G = int'((c >> 8) & 32'hFF);
                  B = int'(c & 32'hFF); end
      2'd1: begin R = int'(c & 32'hFF); G = int'((c >> 8) & 32'hFF);
                  B = int'((c >> 16) & 32'hFF); end
      2'd2: begin R = int'((c >> 24) & 32'hFF); G = int'((c >> 16) & 32'hFF);
                  B = int'((c >> 8) & 32'hFF); end
      default: begin R = int'((c >> 8) & 32'hFF); G = int'((c >> 16) & 32'hFF);
                  B = int'((c >> 24) & 32'hFF); end
    endcase
    if (f == 2'd1 || f == 2'd3) begin
      t = R; R = B; B = t;
    end
    if (f < 2'd2) begin
      q.push_back(8'(R));
      q.push_back(8'(G));
      q.push_back(8'(B));
    end else begin
      v = (R >> 3) * 2048 + (G >> 2) * 32 + (B >> 3);
      q.push_back(8'(v % 256));
      q.push_back(8'(v / 256));
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: oready = 1'b0;
      1: oready = 1'b1;
      default: oready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
      prev_done = 1'b0;
`endif
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 128'(o_valid), 128'(1));
        chk("hold_data", 128'(o_data), 128'(held));
      end
      hold_pend = o_valid && !oready;
      held = o_data;
      if (vin && o_rdy) expand(col, mode, fmt);
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
      if (flush && !flushing) begin
        while (q.size() % OB != 0) q.push_back(8'h00);
        flushing = 1'b1;
      end
      if (prev_done) chk("done_pulse", 128'(done), 128'(0));
      if (done) begin
        chk("drain_empty", 128'(q.size()), 128'(0));
        flushing = 1'b0;
        done_cnt++;
      end
      prev_done = done;
`endif
      if (o_valid && oready) begin
        got.push_back(o_data);
        if (q.size() < OB) begin
          chk("word_extra", 128'(q.size()), 128'(OB));
        end else begin
          for (int i = 0; i < OB; i++) ew[i*8 +: 8] = q.pop_front();
          chk("word", 128'(o_data), 128'(ew));
        end
      end
    end
  end

  task automatic send_px(input logic [31:0] c, input logic [1:0] m,
                         input logic [1:0] f);
    int n;
    n = 0;
    col = c; mode = m; fmt = f; vin = 1'b1;
    @(negedge clk);
    while (!o_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) chk("send_timeout", 128'(o_rdy), 128'(1));
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_words(input string tag, input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 128'(got.size()), 128'(n));
  endtask

  task automatic stream(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = o_rdy;
      @(posedge clk); #1;
      if (acc) col = $urandom;
    end
  endtask

`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
  task automatic wait_done(input string tag);
    int k, s;
    k = 0;
    s = done_cnt;
    while (done_cnt == s && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 128'(done_cnt - s), 128'(1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done("flush_done");
  endtask
`endif

  initial begin
    int px, grp;
    logic [1:0] gm, gf;
    #3;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_data", 128'(o_data), 128'(0));
    chk("rst_ready", 128'(o_rdy), 128'(0));
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    chk("rst_done", 128'(done), 128'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_ready", 128'(o_rdy), 128'(1));

    got.delete();
    send_px(32'h00112233, 2'd0, 2'd0);
    send_px(32'h00445566, 2'd0, 2'd0);
    send_px(32'h00778899, 2'd0, 2'd0);
    send_px(32'h00AABBCC, 2'd0, 2'd0);
    wait_words("t1_cnt", 3);
    chk("t1_w0", 128'(got[0]), 128'(32'h44332211));
    chk("t1_w1", 128'(got[1]), 128'(32'h88776655));
    chk("t1_w2", 128'(got[2]), 128'(32'hCCBBAA99));

    got.delete();
    send_px(32'hFFFF8040, 2'd0, 2'd2);
    send_px(32'hFFFF8040, 2'd0, 2'd2);
    wait_words("t2_cnt", 1);
    chk("t2_w0", 128'(got[0]), 128'(32'hFC08FC08));

`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    got.delete();
    flush = 1'b1;
    send_px(32'h11223344, 2'd2, 2'd1);
    flush = 1'b0;
    wait_done("t3_done");
    chk("t3_cnt", 128'(got.size()), 128'(1));
    chk("t3_w0", 128'(got[0]), 128'(32'h00112233));
`endif

    rmode = 0;
    idle(2);
    mode = 2'd0; fmt = 2'd0;
    col = $urandom;
    vin = 1'b1;
    stream(20);
    chk("bp_ready_low", 128'(o_rdy), 128'(0));
    chk("bp_valid_held", 128'(o_valid), 128'(1));
    rmode = 1;
    stream(20);
    vin = 1'b0;
    idle(20);
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    do_flush();
`endif

    rmode = 2;
    px = 0;
    while (px < 100) begin
      grp = $urandom_range(3, 12);
      gm = 2'($urandom_range(0, 3));
      gf = 2'($urandom_range(0, 3));
      for (int i = 0; i < grp; i++) begin
        idle($urandom_range(0, 2));
        send_px($urandom, gm, gf);
        px++;
      end
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
      do_flush();
`endif
    end
    rmode = 1;
    idle(30);
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    chk("rand_tail", 128'(q.size()), 128'(0));
`endif
    chk("rand_idle", 128'(o_valid), 128'(0));

    rmode = 0;
    idle(2);
    send_px(32'h00010203, 2'd0, 2'd0);
    send_px(32'h00040506, 2'd0, 2'd2);
    idle(3);
    rst = 1'b1;
    q.delete();
`ifdef PAINTERENGINE_GPU_PACKER_FLUSH_EN
    flushing = 1'b0;
`endif
    #1;
    chk("mid_rst_valid", 128'(o_valid), 128'(0));
    chk("mid_rst_data", 128'(o_data), 128'(0));
    chk("mid_rst_ready", 128'(o_rdy), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    rmode = 1;
    send_px(32'h00112233, 2'd0, 2'd0);
    send_px(32'h00445566, 2'd0, 2'd0);
    wait_words("rst_cnt", 1);
    chk("rst_lane0", 128'(got[0]), 128'(32'h44332211));
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
